// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM stage: bus widths, bus layout, load/store codes
// and stall polarity.
package mem_stage_pkg;

  localparam int EX_TO_MEM_WD = 80;
  localparam int MEM_TO_WB_WD = 70;
  localparam int MEM_TO_ID_WD = 38;
  localparam int HILO_WD      = 66;
  localparam int STALL_WD     = 6;
  localparam int DATA_W       = 32;

  localparam logic STOP    = 1'b1;
  localparam logic NO_STOP = 1'b0;

  typedef enum logic [3:0] {
    LD_W  = 4'b0000,
    LD_B  = 4'b0001,
    LD_BU = 4'b0010,
    LD_H  = 4'b0011,
    LD_HU = 4'b0100,
    ST_B  = 4'b0101,
    ST_H  = 4'b0111
  } load_code_e;

  typedef struct packed {
    logic [31:0]       pc;
    logic              ram_en;
    logic [3:0]        ram_wen;
    logic              sel_rf_res;
    logic              rf_we;
    logic [4:0]        rf_waddr;
    logic [DATA_W-1:0] ex_result;
    logic [3:0]        ram_read;
  } ex_to_mem_t;

  function automatic logic is_load(input ex_to_mem_t ex);
    return ex.ram_en & ~|ex.ram_wen;
  endfunction

endpackage

// File: rtl/mem_stage_load_align.sv
// Combinational load alignment: picks the addressed byte/half of an SRAM word
// and sign- or zero-extends it according to the load code.
module mem_stage_load_align
  import mem_stage_pkg::*;
(
  input  logic [3:0]        ram_read,
  input  logic [1:0]        addr,
  input  logic [DATA_W-1:0] word,
  output logic [DATA_W-1:0] result
);

  logic signed [7:0]  byte_sel;
  logic signed [15:0] half_sel;

  always_comb begin
    byte_sel = word[{addr, 3'b000} +: 8];
    half_sel = addr[1] ? word[31:16] : word[15:0];
    result   = word;
    case (ram_read)
      LD_B:    result = DATA_W'(byte_sel);
      LD_BU:   result = {24'b0, byte_sel};
      LD_H:    result = DATA_W'(half_sel);
      LD_HU:   result = {16'b0, half_sel};
      default: result = word;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: registers the EX result and HI/LO bundles, holds SRAM
// read data across stalls and forms the writeback/forwarding buses.
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic                    clk,
  input  logic                    resetn,
  input  logic [STALL_WD-1:0]     stall,
  input  logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
  input  logic [HILO_WD-1:0]      ex_to_mem_hilo,
  input  logic [DATA_W-1:0]       data_sram_rdata,
  output logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus,
  output logic [MEM_TO_ID_WD-1:0] mem_to_id_bus,
  output logic [HILO_WD-1:0]      mem_to_wb_hilo,
  output logic [HILO_WD-1:0]      mem_to_id_hilo,
  output logic                    mem_is_load
);

  ex_to_mem_t         ex_p0;
  logic [HILO_WD-1:0] hilo_p0;
  logic               vld_p0;
  logic               hold_vld_p0;
  logic [DATA_W-1:0]  hold_data_p0;

  logic              advance;
  logic              bubble;
  logic [DATA_W-1:0] rdata_sel;
  logic [DATA_W-1:0] load_data;
  logic [DATA_W-1:0] rf_wdata;
  logic              unused_stall;

  assign advance      = (stall[4] == NO_STOP);
  assign bubble       = (stall[3] == STOP) && advance;
  assign unused_stall = ^{stall[5], stall[2:0]};

  // EX -> MEM input register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ex_p0   <= '0;
      hilo_p0 <= '0;
      vld_p0  <= 1'b0;
    end else if (bubble) begin
      ex_p0   <= '0;
      hilo_p0 <= '0;
      vld_p0  <= 1'b0;
    end else if (advance) begin
      ex_p0   <= ex_to_mem_t'(ex_to_mem_bus);
      hilo_p0 <= ex_to_mem_hilo;
      vld_p0  <= 1'b1;
    end
  end

  // The SRAM only presents its word for one cycle; keep the first one seen
  // while the stage is stalled so the load result survives the stall.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hold_vld_p0  <= 1'b0;
      hold_data_p0 <= '0;
    end else if (advance) begin
      hold_vld_p0  <= 1'b0;
    end else if (vld_p0 && !hold_vld_p0) begin
      hold_vld_p0  <= 1'b1;
      hold_data_p0 <= data_sram_rdata;
    end
  end

  assign rdata_sel = hold_vld_p0 ? hold_data_p0 : data_sram_rdata;

  mem_stage_load_align u_load_align (
    .ram_read (ex_p0.ram_read),
    .addr     (ex_p0.ex_result[1:0]),
    .word     (rdata_sel),
    .result   (load_data)
  );

  assign rf_wdata       = ex_p0.sel_rf_res ? load_data : ex_p0.ex_result;
  assign mem_to_wb_bus  = {ex_p0.pc, ex_p0.rf_we, ex_p0.rf_waddr, rf_wdata};
  assign mem_to_id_bus  = {ex_p0.rf_we, ex_p0.rf_waddr, rf_wdata};
  assign mem_to_wb_hilo = hilo_p0;
  assign mem_to_id_hilo = hilo_p0;
  assign mem_is_load    = is_load(ex_p0);

endmodule
